// File: rtl/da_pack_scheduler.sv
// -----------------------------------------------------------------------------
// da_pack_scheduler
//
// Purpose:
//   Steers the 32-bit USB3 word stream leaving the ram cache into the 24 DA
//   channel RAMs. A header word seen while idle selects the packet type
//   (C/A, NAV or RAW). Every following valid word is payload. Each payload
//   word goes to exactly one channel RAM, with a per-channel word address,
//   one cycle after it is accepted.
//
// Optional feature macro:
//   WATCHDOG_EN - when defined, a packet that stalls for TIMEOUT consecutive
//                 cycles without a valid word is abandoned. The FSM returns
//                 to IDLE and hdr_err pulses. When undefined, stalls are
//                 unbounded and no stall counter exists.
//
// Ports:
//   rdclock    in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   din_valid  in   din carries a word this cycle
//   din        in   32-bit stream word
//   wren_out   out  24-bit one-hot channel-RAM write enable
//                   (7:0 C/A, 15:8 NAV, 23:16 RAW)
//   wr_addr    out  word address inside the active channel
//   wr_data    out  registered copy of the payload word
//   busy       out  high while a packet is in progress (FSM not IDLE)
//   pack_type  out  0 none, 1 C/A, 2 NAV, 3 RAW (last accepted type)
//   frame_done out  one-cycle pulse together with the final write of a packet
//   hdr_err    out  one-cycle pulse on an invalid header (or watchdog abort)
// -----------------------------------------------------------------------------
module da_pack_scheduler #(
  parameter int unsigned CA_LEN  = 32,
  parameter int unsigned NAV_LEN = 10,
  parameter int unsigned RAW_LEN = 64,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              rdclock,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [31:0]       din,
  output logic [23:0]       wren_out,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic [1:0]        pack_type,
  output logic              frame_done,
  output logic              hdr_err
);

  // A channel length that does not fit the address width, or a zero
  // watchdog limit, is a configuration mistake caught at elaboration.
  if (CA_LEN == 0 || NAV_LEN == 0 || RAW_LEN == 0 ||
      CA_LEN > 2**ADDR_W || NAV_LEN > 2**ADDR_W || RAW_LEN > 2**ADDR_W ||
      TIMEOUT == 0) begin : g_bad_cfg
    $error("da_pack_scheduler: illegal channel length, ADDR_W or TIMEOUT");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CA   = 2'd1,
    ST_NAV  = 2'd2,
    ST_RAW  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] CA_LAST  = ADDR_W'(CA_LEN - 1);
  localparam logic [ADDR_W-1:0] NAV_LAST = ADDR_W'(NAV_LEN - 1);
  localparam logic [ADDR_W-1:0] RAW_LAST = ADDR_W'(RAW_LEN - 1);

  state_e              state_q, state_d;
  logic [2:0]          ch_q, ch_d;
  logic [ADDR_W-1:0]   word_q, word_d;
  logic [23:0]         wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [1:0]          pack_type_q, pack_type_d;
  logic                frame_done_q, frame_done_d;
  logic                hdr_err_q, hdr_err_d;

  logic                is_hdr;
  logic [15:0]         hdr_code;
  logic [4:0]          base;
  logic [4:0]          wr_idx;
  logic [ADDR_W-1:0]   last_word;

`ifdef WATCHDOG_EN
  // The counter only ever stores up to TIMEOUT-1; reaching the limit aborts.
  localparam int unsigned STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  logic [STALL_W-1:0]  stall_q, stall_d;
`endif

  // Header pattern: top byte FF, low byte AA, middle 16 bits carry the code.
  assign is_hdr   = ((din & 32'hFF00_00FF) == 32'hFF00_00AA);
  assign hdr_code = din[23:8];

  // Channel bank base and last word index for the packet in progress.
  always_comb begin
    base      = 5'd0;
    last_word = CA_LAST;
    unique case (state_q)
      ST_NAV: begin
        base      = 5'd8;
        last_word = NAV_LAST;
      end
      ST_RAW: begin
        base      = 5'd16;
        last_word = RAW_LAST;
      end
      default: begin
        base      = 5'd0;
        last_word = CA_LAST;
      end
    endcase
  end

  assign wr_idx = base + {2'b00, ch_q};

  // Next-state and output logic. The write strobe is a single cycle per
  // accepted payload word; address/data hold their last written value.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    word_d       = word_q;
    wren_d       = '0;
    addr_d       = addr_q;
    data_d       = data_q;
    pack_type_d  = pack_type_q;
    frame_done_d = 1'b0;
    hdr_err_d    = 1'b0;
`ifdef WATCHDOG_EN
    stall_d      = '0;
`endif

    if (state_q == ST_IDLE) begin
      // Non-header words in IDLE are silently dropped.
      if (din_valid && is_hdr) begin
        ch_d   = '0;
        word_d = '0;
        unique case (hdr_code)
          16'h0000: begin
            state_d     = ST_CA;
            pack_type_d = 2'd1;
          end
          16'h000A: begin
            state_d     = ST_NAV;
            pack_type_d = 2'd2;
          end
          16'h0AAA: begin
            state_d     = ST_RAW;
            pack_type_d = 2'd3;
          end
          16'hAAAA: begin
            // Abort/no-op header: deliberately neither a packet nor an error.
            state_d = ST_IDLE;
          end
          default: hdr_err_d = 1'b1;
        endcase
      end
    end else begin
      // Inside a packet every valid word is payload, header-like or not.
      if (din_valid) begin
        wren_d = 24'd1 << wr_idx;
        addr_d = word_q;
        data_d = din;
        if (word_q == last_word) begin
          word_d = '0;
          if (ch_q == 3'd7) begin
            ch_d         = '0;
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end else begin
            ch_d = ch_q + 3'd1;
          end
        end else begin
          word_d = word_q + 1'b1;
        end
      end
`ifdef WATCHDOG_EN
      else if (stall_q == STALL_LAST) begin
        // Give up on the packet; whatever was written stays in the RAMs.
        state_d   = ST_IDLE;
        hdr_err_d = 1'b1;
        ch_d      = '0;
        word_d    = '0;
      end else begin
        stall_d = stall_q + 1'b1;
      end
`endif
    end
  end

  // State and output registers, all cleared asynchronously by rst.
  always_ff @(posedge rdclock or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      word_q       <= '0;
      wren_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      pack_type_q  <= '0;
      frame_done_q <= 1'b0;
      hdr_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      word_q       <= word_d;
      wren_q       <= wren_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      pack_type_q  <= pack_type_d;
      frame_done_q <= frame_done_d;
      hdr_err_q    <= hdr_err_d;
    end
  end

`ifdef WATCHDOG_EN
  // Consecutive-stall counter, only present with the watchdog.
  always_ff @(posedge rdclock or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

  assign wren_out   = wren_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign busy       = (state_q != ST_IDLE);
  assign pack_type  = pack_type_q;
  assign frame_done = frame_done_q;
  assign hdr_err    = hdr_err_q;

endmodule

// File: tb/tb_da_pack_scheduler.sv
// -----------------------------------------------------------------------------
// tb_da_pack_scheduler
//
// Drives header and payload words into da_pack_scheduler and compares every
// cycle's outputs against a reference that derives channel, address and
// frame end from the payload word index with plain arithmetic.
// Inputs change on the falling edge; outputs are sampled on the next falling
// edge, i.e. after the rising edge that consumed the word.
// -----------------------------------------------------------------------------
module tb_da_pack_scheduler;

  localparam int ADDR_W = 8;

  logic              rdclock = 1'b0;
  logic              rst = 1'b1;
  logic              din_valid = 1'b0;
  logic [31:0]       din = '0;
  logic [23:0]       wren_out;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic [1:0]        pack_type;
  logic              frame_done;
  logic              hdr_err;

  int n_checks = 0;
  int n_fail   = 0;

  da_pack_scheduler #(
    .CA_LEN (32),
    .NAV_LEN(10),
    .RAW_LEN(64),
    .ADDR_W (ADDR_W),
    .TIMEOUT(16)
  ) dut (
    .rdclock   (rdclock),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .wren_out  (wren_out),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .pack_type (pack_type),
    .frame_done(frame_done),
    .hdr_err   (hdr_err)
  );

  // 10 ns clock.
  always #5 rdclock = ~rdclock;

  // Reference model: packet geometry by type (1 C/A, 2 NAV, 3 RAW).
  function automatic int len_of(input int t);
    case (t)
      1:       return 32;
      2:       return 10;
      default: return 64;
    endcase
  endfunction

  function automatic logic [31:0] hdr_of(input int t);
    case (t)
      1:       return 32'hFF0000AA;
      2:       return 32'hFF000AAA;
      default: return 32'hFF0AAAAA;
    endcase
  endfunction

  // Payload word k of a type-t packet lands in channel (t-1)*8 + k/len.
  function automatic logic [23:0] exp_wren(input int t, input int k);
    logic [23:0] e;
    e = '0;
    e[(t - 1) * 8 + k / len_of(t)] = 1'b1;
    return e;
  endfunction

  function automatic logic [ADDR_W-1:0] exp_addr(input int t, input int k);
    return ADDR_W'(k % len_of(t));
  endfunction

  // Present one word for one clock and return on the following falling edge.
  task automatic drive(input logic v, input logic [31:0] d);
    din_valid = v;
    din       = d;
    @(negedge rdclock);
  endtask

  task automatic pulse_reset();
    din_valid = 1'b0;
    rst = 1'b1;
    @(negedge rdclock);
    rst = 1'b0;
    @(negedge rdclock);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    din = '0;
    repeat (2) @(negedge rdclock);
    n_checks++; if (wren_out !== 24'h0) begin n_fail++; $display("[TB] FAIL reset_wren: got %h expected %h", wren_out, 24'h0); end
    n_checks++; if (wr_addr !== '0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected 0", wr_addr); end
    n_checks++; if (wr_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 0", wr_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (pack_type !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_pack_type: got %0d expected 0", pack_type); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++; if (hdr_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hdr_err: got %b expected 0", hdr_err); end
    rst = 1'b0;
    @(negedge rdclock);
  endtask

  task automatic test_ca_packet();
    drive(1'b1, 32'hFF0000AA);
    n_checks++; if (wren_out !== 24'h0) begin n_fail++; $display("[TB] FAIL ca_hdr_wren: got %h expected 0", wren_out); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL ca_hdr_busy: got %b expected 1", busy); end
    n_checks++; if (pack_type !== 2'd1) begin n_fail++; $display("[TB] FAIL ca_hdr_type: got %0d expected 1", pack_type); end
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 32'(k));
      n_checks++; if (wren_out !== exp_wren(1, k)) begin n_fail++; $display("[TB] FAIL ca_wren k=%0d: got %h expected %h", k, wren_out, exp_wren(1, k)); end
      n_checks++; if (wr_addr !== exp_addr(1, k)) begin n_fail++; $display("[TB] FAIL ca_addr k=%0d: got %0d expected %0d", k, wr_addr, exp_addr(1, k)); end
      n_checks++; if (wr_data !== 32'(k)) begin n_fail++; $display("[TB] FAIL ca_data k=%0d: got %h expected %h", k, wr_data, 32'(k)); end
      n_checks++; if (frame_done !== (k == 255)) begin n_fail++; $display("[TB] FAIL ca_frame_done k=%0d: got %b expected %b", k, frame_done, (k == 255)); end
      if (k < 255) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL ca_busy k=%0d: got %b expected 1", k, busy); end
      end
    end
    drive(1'b0, 32'h0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ca_end_busy: got %b expected 0", busy); end
    n_checks++; if (wren_out !== 24'h0) begin n_fail++; $display("[TB] FAIL ca_end_wren: got %h expected 0", wren_out); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL ca_end_frame_done: got %b expected 0", frame_done); end
  endtask

  task automatic test_nav_stalls();
    int per_ch[24];
    int k;
    logic [31:0] d;
    foreach (per_ch[i]) per_ch[i] = 0;
    k = 0;
    drive(1'b1, 32'hFF000AAA);
    n_checks++; if (pack_type !== 2'd2) begin n_fail++; $display("[TB] FAIL nav_hdr_type: got %0d expected 2", pack_type); end
    for (int c = 0; c < 160; c++) begin
      d = $urandom;
      if (c % 2 == 0) begin
        drive(1'b1, d);
        n_checks++; if (wren_out !== exp_wren(2, k)) begin n_fail++; $display("[TB] FAIL nav_wren k=%0d: got %h expected %h", k, wren_out, exp_wren(2, k)); end
        n_checks++; if (wr_addr !== exp_addr(2, k)) begin n_fail++; $display("[TB] FAIL nav_addr k=%0d: got %0d expected %0d", k, wr_addr, exp_addr(2, k)); end
        n_checks++; if (wr_data !== d) begin n_fail++; $display("[TB] FAIL nav_data k=%0d: got %h expected %h", k, wr_data, d); end
        n_checks++; if (frame_done !== (k == 79)) begin n_fail++; $display("[TB] FAIL nav_frame_done k=%0d: got %b expected %b", k, frame_done, (k == 79)); end
        k++;
      end else begin
        drive(1'b0, d);
        n_checks++; if (wren_out !== 24'h0) begin n_fail++; $display("[TB] FAIL nav_stall_wren c=%0d: got %h expected 0", c, wren_out); end
      end
      foreach (per_ch[i]) if (wren_out[i]) per_ch[i]++;
    end
    for (int i = 8; i < 16; i++) begin
      n_checks++; if (per_ch[i] !== 10) begin n_fail++; $display("[TB] FAIL nav_count ch=%0d: got %0d expected 10", i, per_ch[i]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL nav_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_header_robustness();
    pulse_reset();
    drive(1'b1, 32'h12345678);
    n_checks++; if (wren_out !== 24'h0) begin n_fail++; $display("[TB] FAIL hdr_junk_wren: got %h expected 0", wren_out); end
    n_checks++; if (hdr_err !== 1'b0) begin n_fail++; $display("[TB] FAIL hdr_junk_err: got %b expected 0", hdr_err); end
    drive(1'b1, 32'hFF0BADAA);
    n_checks++; if (wren_out !== 24'h0) begin n_fail++; $display("[TB] FAIL hdr_bad_wren: got %h expected 0", wren_out); end
    n_checks++; if (hdr_err !== 1'b1) begin n_fail++; $display("[TB] FAIL hdr_bad_err: got %b expected 1", hdr_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL hdr_bad_busy: got %b expected 0", busy); end
    drive(1'b1, 32'hFFAAAAAA);
    n_checks++; if (hdr_err !== 1'b0) begin n_fail++; $display("[TB] FAIL hdr_abort_err: got %b expected 0", hdr_err); end
    n_checks++; if (wren_out !== 24'h0) begin n_fail++; $display("[TB] FAIL hdr_abort_wren: got %h expected 0", wren_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL hdr_abort_busy: got %b expected 0", busy); end
    n_checks++; if (pack_type !== 2'd0) begin n_fail++; $display("[TB] FAIL hdr_pack_type: got %0d expected 0", pack_type); end
    drive(1'b0, 32'h0);
    n_checks++; if (hdr_err !== 1'b0) begin n_fail++; $display("[TB] FAIL hdr_err_single_pulse: got %b expected 0", hdr_err); end
  endtask

  task automatic test_reset_mid_packet();
    logic [31:0] d;
    drive(1'b1, hdr_of(1));
    for (int k = 0; k < 40; k++) begin
      d = $urandom;
      drive(1'b1, d);
      n_checks++; if (wren_out !== exp_wren(1, k)) begin n_fail++; $display("[TB] FAIL mid_wren k=%0d: got %h expected %h", k, wren_out, exp_wren(1, k)); end
    end
    rst = 1'b1;
    #1;
    n_checks++; if (wren_out !== 24'h0) begin n_fail++; $display("[TB] FAIL mid_rst_wren: got %h expected 0", wren_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", busy); end
    n_checks++; if (pack_type !== 2'd0) begin n_fail++; $display("[TB] FAIL mid_rst_type: got %0d expected 0", pack_type); end
    @(negedge rdclock);
    rst = 1'b0;
    drive(1'b1, hdr_of(2));
    d = $urandom;
    drive(1'b1, d);
    n_checks++; if (wren_out !== 24'h000100) begin n_fail++; $display("[TB] FAIL mid_nav_wren: got %h expected %h", wren_out, 24'h000100); end
    n_checks++; if (wr_addr !== '0) begin n_fail++; $display("[TB] FAIL mid_nav_addr: got %0d expected 0", wr_addr); end
    n_checks++; if (wr_data !== d) begin n_fail++; $display("[TB] FAIL mid_nav_data: got %h expected %h", wr_data, d); end
    n_checks++; if (pack_type !== 2'd2) begin n_fail++; $display("[TB] FAIL mid_nav_type: got %0d expected 2", pack_type); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    pulse_reset();
    drive(1'b1, hdr_of(3));
    for (int k = 0; k < 512; k++) begin
      d = (k == 100) ? 32'hFF0000AA : $urandom;
      drive(1'b1, d);
      n_checks++; if (wren_out !== exp_wren(3, k)) begin n_fail++; $display("[TB] FAIL raw_wren k=%0d: got %h expected %h", k, wren_out, exp_wren(3, k)); end
      n_checks++; if (wr_addr !== exp_addr(3, k)) begin n_fail++; $display("[TB] FAIL raw_addr k=%0d: got %0d expected %0d", k, wr_addr, exp_addr(3, k)); end
      n_checks++; if (wr_data !== d) begin n_fail++; $display("[TB] FAIL raw_data k=%0d: got %h expected %h", k, wr_data, d); end
      n_checks++; if (frame_done !== (k == 511)) begin n_fail++; $display("[TB] FAIL raw_frame_done k=%0d: got %b expected %b", k, frame_done, (k == 511)); end
    end
    drive(1'b1, hdr_of(1));
    n_checks++; if (wren_out !== 24'h0) begin n_fail++; $display("[TB] FAIL b2b_hdr_wren: got %h expected 0", wren_out); end
    n_checks++; if (pack_type !== 2'd1) begin n_fail++; $display("[TB] FAIL b2b_hdr_type: got %0d expected 1", pack_type); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_hdr_busy: got %b expected 1", busy); end
    n_checks++; if (hdr_err !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_hdr_err: got %b expected 0", hdr_err); end
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      drive(1'b1, d);
      n_checks++; if (wren_out !== exp_wren(1, k)) begin n_fail++; $display("[TB] FAIL b2b_ca_wren k=%0d: got %h expected %h", k, wren_out, exp_wren(1, k)); end
      n_checks++; if (wr_addr !== exp_addr(1, k)) begin n_fail++; $display("[TB] FAIL b2b_ca_addr k=%0d: got %0d expected %0d", k, wr_addr, exp_addr(1, k)); end
    end
  endtask

  task automatic test_random_packets();
    int t;
    int k;
    int writes;
    logic v;
    logic [31:0] d;
    pulse_reset();
    for (int p = 0; p < 3; p++) begin
      t = $urandom_range(1, 3);
      // Idle junk: low byte forced to 00 so it can never look like a header.
      for (int j = 0; j < 4; j++) begin
        v = 1'($urandom_range(0, 1));
        drive(v, $urandom & 32'h00FFFF00);
        n_checks++; if (wren_out !== 24'h0) begin n_fail++; $display("[TB] FAIL rnd_idle_wren p=%0d: got %h expected 0", p, wren_out); end
        n_checks++; if (hdr_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_idle_err p=%0d: got %b expected 0", p, hdr_err); end
      end
      drive(1'b1, hdr_of(t));
      n_checks++; if (pack_type !== 2'(t)) begin n_fail++; $display("[TB] FAIL rnd_type p=%0d: got %0d expected %0d", p, pack_type, t); end
      k = 0;
      writes = 0;
      while (k < 8 * len_of(t)) begin
        v = ($urandom_range(0, 3) != 0);
        d = $urandom;
        drive(v, d);
        if (wren_out !== 24'h0) writes++;
        if (v) begin
          n_checks++; if (wren_out !== exp_wren(t, k)) begin n_fail++; $display("[TB] FAIL rnd_wren t=%0d k=%0d: got %h expected %h", t, k, wren_out, exp_wren(t, k)); end
          n_checks++; if (wr_addr !== exp_addr(t, k)) begin n_fail++; $display("[TB] FAIL rnd_addr t=%0d k=%0d: got %0d expected %0d", t, k, wr_addr, exp_addr(t, k)); end
          n_checks++; if (wr_data !== d) begin n_fail++; $display("[TB] FAIL rnd_data t=%0d k=%0d: got %h expected %h", t, k, wr_data, d); end
          n_checks++; if (frame_done !== (k == 8 * len_of(t) - 1)) begin n_fail++; $display("[TB] FAIL rnd_frame_done t=%0d k=%0d: got %b", t, k, frame_done); end
          k++;
        end else begin
          n_checks++; if (wren_out !== 24'h0) begin n_fail++; $display("[TB] FAIL rnd_stall_wren t=%0d k=%0d: got %h expected 0", t, k, wren_out); end
        end
      end
      n_checks++; if (writes !== 8 * len_of(t)) begin n_fail++; $display("[TB] FAIL rnd_write_count t=%0d: got %0d expected %0d", t, writes, 8 * len_of(t)); end
      drive(1'b0, 32'h0);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_end_busy t=%0d: got %b expected 0", t, busy); end
    end
  endtask

`ifdef WATCHDOG_EN
  task automatic test_watchdog();
    pulse_reset();
    drive(1'b1, hdr_of(1));
    for (int k = 0; k < 5; k++) drive(1'b1, $urandom);
    for (int s = 1; s <= 16; s++) begin
      drive(1'b0, 32'h0);
      if (s < 16) begin
        n_checks++; if (hdr_err !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_early_err s=%0d: got %b expected 0", s, hdr_err); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_early_busy s=%0d: got %b expected 1", s, busy); end
      end else begin
        n_checks++; if (hdr_err !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_err: got %b expected 1", hdr_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_busy: got %b expected 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_frame_done: got %b expected 0", frame_done); end
      end
    end
    drive(1'b0, 32'h0);
    n_checks++; if (hdr_err !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_err_single_pulse: got %b expected 0", hdr_err); end
  endtask
`endif

  // Scenario sequence.
  initial begin
    $display("[TB] start");
    test_reset();
    test_ca_packet();
    test_nav_stalls();
    test_header_robustness();
    test_reset_mid_packet();
    test_back_to_back();
    test_random_packets();
`ifdef WATCHDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/da_pack_scheduler.md
Name: da_pack_scheduler

Overview:
- Sequences the DA channel-RAM write enables from the 32-bit USB3 word stream leaving the ram cache.
- Decodes header words into a packet type, then steers each following payload word to exactly one of 24 channel RAMs: 8 C/A-code, 8 navigation-message and 8 raw.
- Each write carries a per-channel word address.
- Replaces ad-hoc com_state sequencing with one FSM with explicit stall, abort and error handling.

Parameters:
- CA_LEN, 32: words per C/A channel (channels 0-7, wren bits 7:0).
- NAV_LEN, 10: words per navigation channel (channels 8-15, wren bits 15:8).
- RAW_LEN, 64: words per raw channel (channels 16-23, wren bits 23:16).
- ADDR_W, 8: width of wr_addr. Each *_LEN must be ≤ 2^ADDR_W.
- TIMEOUT, 1023: stall watchdog limit in cycles (used only with WATCHDOG_EN).

Ports:
- rdclock  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din_valid  in  1  din carries a word this cycle.
- din  in  32  stream word from the ram cache.
- wren_out  out  24  one-hot channel-RAM write enable.
- wr_addr  out  ADDR_W  word address within the active channel.
- wr_data  out  32  registered copy of the payload word.
- busy  out  1  high while not in IDLE.
- pack_type  out  2  0=none, 1=C/A, 2=NAV, 3=RAW; holds the current/last accepted type.
- frame_done  out  1  one-cycle pulse after the last word of channel 7 / 15 / 23.
- hdr_err  out  1  one-cycle pulse on an invalid header or abort.

Behaviour:
- Reset (async, any state): FSM to IDLE. wren_out=0, wr_addr=0, wr_data=0, busy=0, pack_type=0, frame_done=0, hdr_err=0. Channel and word counters = 0.
- Header test, applied only in IDLE with din_valid=1: (din & 32'hFF0000FF) == 32'hFF0000AA. Code = din[23:8]:
  - 0x0000: go to CA, pack_type=1.
  - 0x000A: go to NAV, pack_type=2.
  - 0x0AAA: go to RAW, pack_type=3.
  - 0xAAAA: abort/no-op. Stay in IDLE, no error.
  - Any other code: stay in IDLE, hdr_err pulse.
- In IDLE, a valid non-header word is discarded. No write, no error.
- Payload (CA/NAV/RAW): every din_valid=1 word is payload. Header patterns are NOT decoded inside a packet.
- Latency is 1 cycle. Payload word accepted at cycle N gives, at N+1: wren_out = one-hot of (base + ch), wr_addr = word index, wr_data = din. Base is 0 for CA, 8 for NAV, 16 for RAW.
- With din_valid=0, wren_out=0 the next cycle and all counters hold (stall, no timeout by default).
- Word counter runs 0..LEN-1. At LEN-1 it wraps to 0 and ch increments. A write with word=LEN-1 and ch=7 ends the packet:
  - FSM returns to IDLE.
  - frame_done pulses in the same cycle as that last write.
- The header word itself never produces a write. The next valid word is written at address 0 of channel base+0.
- busy goes high the cycle after a header is accepted and low the cycle after the final write.
- wren_out is one-hot or zero at all times. Exactly CA_LEN*8, NAV_LEN*8 or RAW_LEN*8 writes occur per packet.
- A header word arriving back-to-back in the cycle after frame_done is accepted. There is no dead cycle.

Optional Feature:
- Macro: WATCHDOG_EN.
- Defined: in CA/NAV/RAW, a counter counts consecutive din_valid=0 cycles and clears on any valid word. When it reaches TIMEOUT:
  - FSM goes to IDLE, hdr_err pulses, frame_done stays 0.
  - Partially written channels are left as is.
- Undefined: no counter is built. Stalls are unbounded.

Test Plan:
- Reset mid-packet: after CA header + 40 words, assert rst → next cycle wren_out=0, busy=0, pack_type=0. A new NAV header then starts at channel 8, addr 0.
- CA packet: header 0xFF0000AA + 256 words 0..255, din_valid continuous → word k lands on wren bit k/32, addr k%32, 1-cycle latency. frame_done pulses with word 255.
- NAV packet with stalls: header 0xFF000AAA + 80 words, din_valid toggling 1/0 → bits 8..15 each get 10 writes, addr 0..9. No write in stall cycles.
- Header robustness: in IDLE send 0x12345678, then 0xFF0BADAA, then 0xFFAAAAAA → no writes; one hdr_err pulse (second word only); pack_type stays 0.
- RAW then back-to-back CA: RAW header + 512 words, then a CA header in the next cycle → bits 16..23 get 64 writes each. The CA header is accepted with no gap; a payload word equal to 0xFF0000AA inside RAW is written as data.
- WATCHDOG_EN, TIMEOUT=16: CA header + 5 words, then din_valid=0 for 16 cycles → hdr_err pulse, busy=0, frame_done=0.
